// File: rtl/mult_issue_queue_pkg.sv
// Shared types for the multiplier issue queue: CDB bundle, issue bundle, queue entry.
package mult_issue_queue_pkg;

  localparam int TAG_W = 6;
  localparam int XLEN  = 32;

  typedef struct packed {
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_result;
  } cdb_bfm;

  typedef struct packed {
    logic [TAG_W-1:0] rd_tag;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
  } common_fifo_data;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] rs1_tag;
    logic [XLEN-1:0]  rs1_data;
    logic             rs1_rdy;
    logic [TAG_W-1:0] rs2_tag;
    logic [XLEN-1:0]  rs2_data;
    logic             rs2_rdy;
  } mult_iq_entry_t;

  // Operand state for a freshly dispatched source: returns {rdy, data}.
  // A pending operand whose producer broadcasts this same cycle is captured now.
  function automatic logic [XLEN:0] capture_src(input logic vld,
                                                input logic [TAG_W-1:0] tag,
                                                input logic [XLEN-1:0] data,
                                                input cdb_bfm cdb);
    if (vld)
      return {1'b1, data};
    else if (cdb.cdb_valid && (cdb.cdb_tag == tag))
      return {1'b1, cdb.cdb_result};
    else
      return {1'b0, data};
  endfunction

endpackage

// File: rtl/mult_issue_queue_iq_entry_wakeup.sv
// Per-entry, per-operand CDB tag compare; yields the operand's next ready/data.
module iq_entry_wakeup
  import mult_issue_queue_pkg::*;
(
  input  logic             ent_vld,
  input  logic             src_rdy,
  input  logic [TAG_W-1:0] src_tag,
  input  logic [XLEN-1:0]  src_data,
  input  cdb_bfm           cdb,
  output logic             rdy_nxt,
  output logic [XLEN-1:0]  data_nxt
);

  logic hit;

  always_comb begin
    hit      = ent_vld && !src_rdy && cdb.cdb_valid && (src_tag == cdb.cdb_tag);
    rdy_nxt  = src_rdy | hit;
    data_nxt = hit ? cdb.cdb_result : src_data;
  end

endmodule

// File: rtl/mult_issue_queue.sv
// In-order MUL issue queue with CDB operand wakeup.
// Optional MULT_IQ_FWD_EN: head may issue in the same cycle its last operand is broadcast.
module mult_issue_queue
  import mult_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4
)(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       disp_valid,
  input  logic [TAG_W-1:0]           disp_rd_tag,
  input  logic [TAG_W-1:0]           disp_rs1_tag,
  input  logic [XLEN-1:0]            disp_rs1_data,
  input  logic                       disp_rs1_valid,
  input  logic [TAG_W-1:0]           disp_rs2_tag,
  input  logic [XLEN-1:0]            disp_rs2_data,
  input  logic                       disp_rs2_valid,
  output logic                       disp_full,
  input  cdb_bfm                     cdb_in,
  input  logic                       issue_grant,
  output logic                       issue_queue_rdy,
  output common_fifo_data            mult_exec_fifo_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  mult_iq_entry_t ent_q [DEPTH];
  mult_iq_entry_t ent_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [DEPTH-1:0]           rs1_rdy_nxt, rs2_rdy_nxt;
  logic [DEPTH-1:0][XLEN-1:0] rs1_data_nxt, rs2_data_nxt;

  logic            push, pop;
  logic            h_rs1_rdy, h_rs2_rdy;
  logic [XLEN-1:0] h_rs1_data, h_rs2_data;
  logic [XLEN:0]   cap1, cap2;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    iq_entry_wakeup u_rs1 (
      .ent_vld  (ent_q[g].valid),
      .src_rdy  (ent_q[g].rs1_rdy),
      .src_tag  (ent_q[g].rs1_tag),
      .src_data (ent_q[g].rs1_data),
      .cdb      (cdb_in),
      .rdy_nxt  (rs1_rdy_nxt[g]),
      .data_nxt (rs1_data_nxt[g])
    );
    iq_entry_wakeup u_rs2 (
      .ent_vld  (ent_q[g].valid),
      .src_rdy  (ent_q[g].rs2_rdy),
      .src_tag  (ent_q[g].rs2_tag),
      .src_data (ent_q[g].rs2_data),
      .cdb      (cdb_in),
      .rdy_nxt  (rs2_rdy_nxt[g]),
      .data_nxt (rs2_data_nxt[g])
    );
  end

  always_comb begin
`ifdef MULT_IQ_FWD_EN
    // Post-wakeup view of the head lets a same-cycle broadcast complete it.
    h_rs1_rdy  = rs1_rdy_nxt[head_q];
    h_rs2_rdy  = rs2_rdy_nxt[head_q];
    h_rs1_data = rs1_data_nxt[head_q];
    h_rs2_data = rs2_data_nxt[head_q];
`else
    h_rs1_rdy  = ent_q[head_q].rs1_rdy;
    h_rs2_rdy  = ent_q[head_q].rs2_rdy;
    h_rs1_data = ent_q[head_q].rs1_data;
    h_rs2_data = ent_q[head_q].rs2_data;
`endif
    disp_full       = (count_q == FULL_CNT);
    issue_queue_rdy = ent_q[head_q].valid && h_rs1_rdy && h_rs2_rdy;
    mult_exec_fifo_data = '0;
    if (ent_q[head_q].valid)
      mult_exec_fifo_data = '{rd_tag: ent_q[head_q].rd_tag, rs1_data: h_rs1_data,
                              rs2_data: h_rs2_data};
    count = count_q;
  end

  always_comb begin
    push   = disp_valid && !disp_full;
    pop    = issue_grant && issue_queue_rdy;
    cap1   = capture_src(disp_rs1_valid, disp_rs1_tag, disp_rs1_data, cdb_in);
    cap2   = capture_src(disp_rs2_valid, disp_rs2_tag, disp_rs2_data, cdb_in);
    head_d = head_q;
    tail_d = tail_q;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i]          = ent_q[i];
      ent_d[i].rs1_rdy  = rs1_rdy_nxt[i];
      ent_d[i].rs1_data = rs1_data_nxt[i];
      ent_d[i].rs2_rdy  = rs2_rdy_nxt[i];
      ent_d[i].rs2_data = rs2_data_nxt[i];
    end
    if (pop) begin
      ent_d[head_q].valid = 1'b0;
      head_d = head_q + PTR_W'(1);
    end
    // Push and pop never target the same slot: push needs count<DEPTH, pop needs count>0.
    if (push) begin
      ent_d[tail_q] = '{valid: 1'b1, rd_tag: disp_rd_tag,
                        rs1_tag: disp_rs1_tag, rs1_data: cap1[XLEN-1:0], rs1_rdy: cap1[XLEN],
                        rs2_tag: disp_rs2_tag, rs2_data: cap2[XLEN-1:0], rs2_rdy: cap2[XLEN]};
      tail_d = tail_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: tb/tb_mult_issue_queue.sv
// Directed bench for mult_issue_queue; expectations hand-derived, both MULT_IQ_FWD_EN builds.
module tb_mult_issue_queue;
  import mult_issue_queue_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             disp_valid;
  logic [TAG_W-1:0] disp_rd_tag, disp_rs1_tag, disp_rs2_tag;
  logic [XLEN-1:0]  disp_rs1_data, disp_rs2_data;
  logic             disp_rs1_valid, disp_rs2_valid;
  logic             disp_full;
  cdb_bfm           cdb_in;
  logic             issue_grant;
  logic             issue_queue_rdy;
  common_fifo_data  mult_exec_fifo_data;
  logic [2:0]       count;

  int passed = 0;
  int total  = 0;

  mult_issue_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_rd_tag(disp_rd_tag),
    .disp_rs1_tag(disp_rs1_tag), .disp_rs1_data(disp_rs1_data), .disp_rs1_valid(disp_rs1_valid),
    .disp_rs2_tag(disp_rs2_tag), .disp_rs2_data(disp_rs2_data), .disp_rs2_valid(disp_rs2_valid),
    .disp_full(disp_full), .cdb_in(cdb_in), .issue_grant(issue_grant),
    .issue_queue_rdy(issue_queue_rdy), .mult_exec_fifo_data(mult_exec_fifo_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic common_fifo_data mkd(input int rd, input int a, input int b);
    return '{rd_tag: TAG_W'(rd), rs1_data: XLEN'(a), rs2_data: XLEN'(b)};
  endfunction

  task automatic disp(input int rd, input int t1, input int d1, input logic v1,
                      input int t2, input int d2, input logic v2);
    disp_valid     = 1'b1;
    disp_rd_tag    = TAG_W'(rd);
    disp_rs1_tag   = TAG_W'(t1);
    disp_rs1_data  = XLEN'(d1);
    disp_rs1_valid = v1;
    disp_rs2_tag   = TAG_W'(t2);
    disp_rs2_data  = XLEN'(d2);
    disp_rs2_valid = v2;
  endtask

  task automatic bcast(input int tag, input int res);
    cdb_in = '{cdb_valid: 1'b1, cdb_tag: TAG_W'(tag), cdb_result: XLEN'(res)};
  endtask

  initial begin
    rst_n = 1'b0; disp_valid = 1'b0; issue_grant = 1'b0; cdb_in = '0;
    disp_rd_tag = '0; disp_rs1_tag = '0; disp_rs2_tag = '0;
    disp_rs1_data = '0; disp_rs2_data = '0; disp_rs1_valid = 1'b0; disp_rs2_valid = 1'b0;
    step(); step();
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_rdy",   128'(issue_queue_rdy), 128'(0));
    chk("rst_full",  128'(disp_full), 128'(0));
    chk("rst_data",  128'(mult_exec_fifo_data), 128'(0));
    rst_n = 1'b1;

    // 1: both operands ready at dispatch
    disp(5, 1, 3, 1'b1, 2, 7, 1'b1); issue_grant = 1'b1;
    step(); disp_valid = 1'b0;
    chk("t1_rdy",   128'(issue_queue_rdy), 128'(1));
    chk("t1_data",  128'(mult_exec_fifo_data), 128'(mkd(5, 3, 7)));
    chk("t1_count", 128'(count), 128'(1));
    step(); issue_grant = 1'b0;
    chk("t1_count_after", 128'(count), 128'(0));
    chk("t1_data_empty",  128'(mult_exec_fifo_data), 128'(0));

    // 2: rs2 pending on tag 12, woken by the CDB
    disp(9, 1, 2, 1'b1, 12, 0, 1'b0);
    step(); disp_valid = 1'b0;
    chk("t2_wait_rdy", 128'(issue_queue_rdy), 128'(0));
    bcast(12, 'h10); #1;
`ifdef MULT_IQ_FWD_EN
    chk("t2_fwd_rdy",  128'(issue_queue_rdy), 128'(1));
    chk("t2_fwd_data", 128'(mult_exec_fifo_data), 128'(mkd(9, 2, 'h10)));
`else
    chk("t2_bcast_rdy", 128'(issue_queue_rdy), 128'(0));
`endif
    step(); cdb_in = '0; #1;
    chk("t2_rdy",  128'(issue_queue_rdy), 128'(1));
    chk("t2_data", 128'(mult_exec_fifo_data), 128'(mkd(9, 2, 'h10)));
    issue_grant = 1'b1; step(); issue_grant = 1'b0;
    chk("t2_count", 128'(count), 128'(0));

    // 3: dispatch captures a same-cycle broadcast
    disp(6, 4, 0, 1'b0, 1, 5, 1'b1); bcast(4, 'hAB);
    step(); disp_valid = 1'b0; cdb_in = '0; #1;
    chk("t3_rdy",  128'(issue_queue_rdy), 128'(1));
    chk("t3_data", 128'(mult_exec_fifo_data), 128'(mkd(6, 'hAB, 5)));
    issue_grant = 1'b1; step(); issue_grant = 1'b0;
    chk("t3_count", 128'(count), 128'(0));

    // 4: fill, overflow attempt, wrap and in-order drain
    for (int i = 0; i < 4; i++) begin
      disp(20 + i, 0, i, 1'b1, 0, 100 + i, 1'b1);
      step();
    end
    chk("t4_count_full", 128'(count), 128'(4));
    chk("t4_full",       128'(disp_full), 128'(1));
    disp(30, 0, 99, 1'b1, 0, 99, 1'b1);
    step(); disp_valid = 1'b0;
    chk("t4_count_ovf", 128'(count), 128'(4));
    chk("t4_head0",     128'(mult_exec_fifo_data), 128'(mkd(20, 0, 100)));
    issue_grant = 1'b1; step(); issue_grant = 1'b0; #1;
    chk("t4_not_full", 128'(disp_full), 128'(0));
    chk("t4_count3",   128'(count), 128'(3));
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("t4_head%0d", i), 128'(mult_exec_fifo_data), 128'(mkd(20 + i, i, 100 + i)));
      issue_grant = 1'b1; step(); issue_grant = 1'b0;
    end
    chk("t4_drained", 128'(count), 128'(0));

    // 5: stalled head blocks a ready younger entry
    disp(40, 33, 0, 1'b0, 0, 2, 1'b1); step();
    disp(41, 0, 7, 1'b1, 0, 8, 1'b1);  step();
    disp_valid = 1'b0; issue_grant = 1'b1;
    step(); step();
    chk("t5_blocked_rdy",   128'(issue_queue_rdy), 128'(0));
    chk("t5_blocked_count", 128'(count), 128'(2));
    chk("t5_head_tag",      128'(mult_exec_fifo_data.rd_tag), 128'(40));
    issue_grant = 1'b0;
    bcast(33, 'h55); step(); cdb_in = '0; #1;
    chk("t5_head_rdy",  128'(issue_queue_rdy), 128'(1));
    chk("t5_head_data", 128'(mult_exec_fifo_data), 128'(mkd(40, 'h55, 2)));
    issue_grant = 1'b1; step();
    chk("t5_second",       128'(mult_exec_fifo_data), 128'(mkd(41, 7, 8)));
    chk("t5_second_count", 128'(count), 128'(1));
    step(); issue_grant = 1'b0;
    chk("t5_empty", 128'(count), 128'(0));

    // 6: reset with entries held
    for (int i = 0; i < 3; i++) begin
      disp(50 + i, 60, 0, 1'b0, 0, 1, 1'b1);
      step();
    end
    disp_valid = 1'b0; #1;
    chk("t6_held", 128'(count), 128'(3));
    rst_n = 1'b0; step();
    chk("t6_count", 128'(count), 128'(0));
    chk("t6_rdy",   128'(issue_queue_rdy), 128'(0));
    chk("t6_full",  128'(disp_full), 128'(0));
    chk("t6_data",  128'(mult_exec_fifo_data), 128'(0));
    rst_n = 1'b1;
    disp(55, 0, 11, 1'b1, 0, 12, 1'b1); step(); disp_valid = 1'b0; #1;
    chk("t6_post_count", 128'(count), 128'(1));
    chk("t6_post_data",  128'(mult_exec_fifo_data), 128'(mkd(55, 11, 12)));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mult_issue_queue.md
Name: mult_issue_queue

Overview:
In-order issue queue that sits directly upstream of the multiplier execution stage in the RISC-V out-of-order core.
- Accepts dispatched MUL instructions and holds them until both source operands are valid.
- Operands are captured by snooping the CDB.
- Presents the head entry as a common_fifo_data bundle with issue_queue_rdy, and pops it when the multiplier pipe accepts it.

Parameters:
DEPTH, 4, number of queue entries; power of 2, minimum 2.
TAG_W, 6, ROB/rename tag width; taken from the package constant.
XLEN, 32, operand/result width; taken from the package constant.

Ports:
clk  input  1  core clock.
rst_n  input  1  synchronous active-low reset; sampled on the rising edge of clk.
disp_valid  input  1  dispatch request.
disp_rd_tag  input  TAG_W  destination tag.
disp_rs1_tag  input  TAG_W  rs1 producer tag.
disp_rs1_data  input  XLEN  rs1 value; meaningful when disp_rs1_valid=1.
disp_rs1_valid  input  1  rs1 value is already available.
disp_rs2_tag / disp_rs2_data / disp_rs2_valid  input  TAG_W / XLEN / 1  same as rs1, for rs2.
disp_full  output  1  queue cannot accept a dispatch this cycle.
cdb_in  input  $bits(cdb_bfm)  CDB broadcast (cdb_valid, cdb_tag, cdb_result).
issue_grant  input  1  multiplier pipe accepts the head entry this cycle.
issue_queue_rdy  output  1  head entry is valid and both operands are ready.
mult_exec_fifo_data  output  $bits(common_fifo_data)  head rd_tag, rs1_data, rs2_data.
count  output  $clog2(DEPTH)+1  occupancy.

Behaviour:
Storage and reset
- Circular buffer with head/tail pointers of $clog2(DEPTH) bits that wrap naturally, plus an occupancy counter.
- Each entry holds: valid, rd_tag, rs1_tag, rs1_data, rs1_rdy, rs2_tag, rs2_data, rs2_rdy.
- Reset (rst_n=0 at a clk edge): head=tail=count=0, all entry valid/rdy bits 0.
- Output reset values: disp_full=0, issue_queue_rdy=0, mult_exec_fifo_data=0.
- Reset mid-operation discards all entries. The first dispatch is accepted on the first edge after rst_n=1.

Push and pop
- disp_full = (count==DEPTH).
- Push happens when disp_valid && !disp_full. The entry is written at tail and tail increments.
- A dispatch while full is ignored; the upstream stage is responsible for holding it.
- Pop happens when issue_grant && issue_queue_rdy. The head valid bit clears and head increments.
- issue_grant without issue_queue_rdy has no effect.
- Simultaneous push and pop: count is unchanged. When full, a same-cycle pop does not enable the push, because disp_full is registered-count based.

CDB wakeup
- When cdb_in.cdb_valid=1, every valid entry with rsX_rdy=0 and rsX_tag==cdb_tag latches cdb_result and sets rsX_rdy.
- rs1 and rs2 are matched independently; both may wake on the same broadcast.
- Dispatch capture: if the entry being pushed has disp_rsX_valid=0 and its tag matches the same-cycle CDB broadcast, it is written with the CDB result and rdy=1. This is mandatory; without it the entry would never wake.

Issue
- issue_queue_rdy = head valid && rs1_rdy && rs2_rdy; combinational from registers.
- mult_exec_fifo_data is driven from the head entry whenever head is valid, and is 0 when empty.
- Issue is strictly in order; a younger ready entry never bypasses a stalled head.

Optional Feature:
MULT_IQ_FWD_EN
- Defined: the head entry may issue in the same cycle its last missing operand appears on the CDB.
  - issue_queue_rdy includes the CDB tag match.
  - mult_exec_fifo_data muxes in cdb_result for that operand.
- Undefined: the operand is latched first and issue_queue_rdy rises the following cycle. The CDB-to-issue path is one cycle longer.

Decomposition:
Package (utils.sv):
- TAG_W and XLEN constants.
- Existing common_fifo_data and cdb_bfm typedefs.
- New mult_iq_entry_t packed struct for the entry fields.

Sub-module: iq_entry_wakeup, the per-entry, per-operand tag-compare-and-capture logic, instantiated 2*DEPTH times via generate.

Test Plan:
1. Dispatch rd_tag=5, rs1=3 valid, rs2=7 valid, issue_grant=1 -> issue_queue_rdy=1 the next cycle; mult_exec_fifo_data={5,3,7}; count returns to 0 after the grant.
2. Dispatch rd_tag=9 with rs2 pending tag 12; later CDB {valid, tag 12, result 0x10} -> issue_queue_rdy rises 1 cycle after the broadcast (0 cycles with MULT_IQ_FWD_EN); rs2_data=0x10.
3. Dispatch with rs1 pending tag 4 in the same cycle as CDB tag 4 result 0xAB -> the entry is captured ready; it issues with rs1_data=0xAB and never hangs.
4. Fill 4 entries with no grant -> disp_full=1; a 5th dispatch is ignored; after one grant disp_full=0; pointers wrap and entries emerge in order.
5. Head pending, entry 2 ready -> head blocks issue; entry 2 issues only after the head wakes and pops.
6. rst_n=0 with 3 entries held -> next cycle count=0, issue_queue_rdy=0, disp_full=0, data=0.
